// File: rtl/nor_chain_pulse_sequencer.sv
// Pulse-train stimulus controller for NOR/INV delay chains: programmable width/gap/count, settle window, done pulse.
// Define NOR_CHAIN_EDGE_COUNT_EN to build the chain_out synchroniser and edge counter behind out_edges.
module nor_chain_pulse_sequencer #(
  parameter int CNT_W      = 16,
  parameter int NP_W       = 8,
  parameter int SETTLE_CYC = 64,
  parameter int EDGE_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  gap_width,
  input  logic [NP_W-1:0]   num_pulses,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] out_edges
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HIGH   = 3'd1;
  localparam logic [2:0] S_LOW    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_gap;
  logic [NP_W-1:0]  r_left;
  logic             r_chain_in;

  logic [CNT_W-1:0] w_pw_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic             w_busy;
  logic             w_launch;

  assign w_pw_eff  = (pulse_width == '0) ? CNT_ONE : pulse_width;
  assign w_gap_eff = (gap_width == '0) ? CNT_ONE : gap_width;
  assign w_busy    = (r_state == S_HIGH) || (r_state == S_LOW) || (r_state == S_SETTLE);
  assign w_launch  = (r_state == S_IDLE) && start;

  // Phase counters load the full phase length on entry and leave the phase when they reach 1.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pw       <= '0;
      r_gap      <= '0;
      r_left     <= '0;
      r_chain_in <= 1'b0;
    end else if (abort && w_busy) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_left     <= '0;
      r_chain_in <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pw  <= w_pw_eff;
            r_gap <= w_gap_eff;
            if (num_pulses != '0) begin
              r_state    <= S_HIGH;
              r_cnt      <= w_pw_eff;
              r_left     <= num_pulses;
              r_chain_in <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
              r_cnt   <= SETTLE_LD;
              r_left  <= '0;
            end
          end
        end
        S_HIGH: begin
          if (r_cnt == CNT_ONE) begin
            r_left     <= r_left - 1'b1;
            r_chain_in <= 1'b0;
            if (r_left > NP_W'(1)) begin
              r_state <= S_LOW;
              r_cnt   <= r_gap;
            end else begin
              r_state <= S_SETTLE;
              r_cnt   <= SETTLE_LD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == CNT_ONE) begin
            r_state    <= S_HIGH;
            r_cnt      <= r_pw;
            r_chain_in <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_chain_in <= 1'b0;
        end
      endcase
    end
  end

  assign chain_in = r_chain_in;
  assign busy     = w_busy;
  assign done     = (r_state == S_DONE);

`ifdef NOR_CHAIN_EDGE_COUNT_EN
  localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync3;
  logic [EDGE_W-1:0] r_edges;
  logic              w_edge;

  assign w_edge = r_sync2 ^ r_sync3;

  // chain_out is asynchronous to clk; two flops resolve metastability before the edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edges <= '0;
    end else begin
      r_sync1 <= chain_out;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_launch) begin
        r_edges <= '0;
      end else if (w_busy && w_edge && (r_edges != EDGE_MAX)) begin
        r_edges <= r_edges + 1'b1;
      end
    end
  end

  assign out_edges = r_edges;
`else
  logic w_unused;

  assign w_unused  = chain_out ^ w_launch;
  assign out_edges = '0;
`endif

endmodule

// File: tb/tb_nor_chain_pulse_sequencer.sv
// Self-checking bench: directed scenarios plus randomized trains against a waveform-list reference model.
module tb_nor_chain_pulse_sequencer;

  localparam int CNT_W      = 16;
  localparam int NP_W       = 8;
  localparam int SETTLE_CYC = 64;
  localparam int EDGE_W     = 16;
  localparam int CHAIN_DLY  = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  pulse_width;
  logic [CNT_W-1:0]  gap_width;
  logic [NP_W-1:0]   num_pulses;
  logic              chain_in;
  logic              chain_out;
  logic              busy;
  logic              done;
  logic [EDGE_W-1:0] out_edges;

  logic [CHAIN_DLY-1:0] r_dly;

  int n_cmp = 0;
  int n_mis = 0;

  nor_chain_pulse_sequencer #(
    .CNT_W(CNT_W), .NP_W(NP_W), .SETTLE_CYC(SETTLE_CYC), .EDGE_W(EDGE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pulse_width(pulse_width), .gap_width(gap_width), .num_pulses(num_pulses),
    .chain_in(chain_in), .chain_out(chain_out), .busy(busy), .done(done),
    .out_edges(out_edges)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay-chain stand-in: chain_out follows chain_in a fixed number of clocks later.
  always @(posedge clk or posedge rst) begin
    if (rst) r_dly <= '0;
    else     r_dly <= {r_dly[CHAIN_DLY-2:0], chain_in};
  end
  assign chain_out = r_dly[CHAIN_DLY-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected chain_in level for each cycle after launch: pulses, gaps, then settle.
  task automatic build_wave(input int pw, input int gap, input int np, output bit wave[$]);
    int pwe;
    int gape;
    pwe  = (pw == 0) ? 1 : pw;
    gape = (gap == 0) ? 1 : gap;
    wave = {};
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < pwe; i++) wave.push_back(1'b1);
      if (p != np - 1)
        for (int i = 0; i < gape; i++) wave.push_back(1'b0);
    end
    for (int i = 0; i < SETTLE_CYC; i++) wave.push_back(1'b0);
  endtask

  // Edges of chain_in that reach the counter while busy: synchroniser plus loop delay is CHAIN_DLY+2 cycles.
  function automatic int expected_edges(input bit wave[$]);
    int n;
    bit prev;
    n = 0;
`ifdef NOR_CHAIN_EDGE_COUNT_EN
    prev = 1'b0;
    for (int j = 1; j <= wave.size() - (CHAIN_DLY + 2); j++) begin
      if (wave[j-1] != prev) n++;
      prev = wave[j-1];
    end
`else
    prev = 1'b0;
    n = int'(prev);
`endif
    return n;
  endfunction

  task automatic run_train(input int pw, input int gap, input int np, input bit noisy, input string tag);
    bit wave[$];
    int len;
    int exp_e;
    build_wave(pw, gap, np, wave);
    len   = wave.size();
    exp_e = expected_edges(wave);
    @(negedge clk);
    pulse_width = CNT_W'(pw);
    gap_width   = CNT_W'(gap);
    num_pulses  = NP_W'(np);
    abort       = 1'b0;
    start       = 1'b1;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      check({tag, ".chain_in"}, 32'(chain_in), (k <= len) ? 32'(wave[k-1]) : 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'(k <= len));
      check({tag, ".done"}, 32'(done), 32'(k == len + 1));
      if (k == len + 1) check({tag, ".out_edges"}, 32'(out_edges), 32'(exp_e));
      if (k <= len) begin
        start = noisy ? 1'($urandom) : 1'b0;
        if (noisy) begin
          pulse_width = CNT_W'($urandom);
          gap_width   = CNT_W'($urandom);
          num_pulses  = NP_W'($urandom);
        end
      end else if (k == len + 1) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    bit wave[$];
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pulse_width = '0; gap_width = '0; num_pulses = '0;

    @(negedge clk);
    check("reset.chain_in", 32'(chain_in), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.out_edges", 32'(out_edges), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_train(3, 2, 2, 1'b0, "basic");
    run_train(0, 0, 3, 1'b0, "zero_w");
    run_train(0, 7, 0, 1'b0, "np_zero");
    run_train(4, 4, 3, 1'b0, "loop_edges");

    // Extra start mid-train, then abort in the second HIGH phase.
    build_wave(3, 2, 3, wave);
    @(negedge clk);
    pulse_width = 3; gap_width = 2; num_pulses = 3; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("abort.pre_chain_in", 32'(chain_in), 32'(wave[k-1]));
      check("abort.pre_busy", 32'(busy), 32'd1);
      start = (k == 3);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.chain_in", 32'(chain_in), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    for (int k = 0; k < 15; k++) begin
      check("abort.no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("abort.idle_chain_in", 32'(chain_in), 32'd0);
    check("abort.idle_busy", 32'(busy), 32'd0);
    check("abort.out_edges_held", 32'(out_edges), 32'd0);

    for (int r = 0; r < 8; r++)
      run_train(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 5)), 1'b1, "rand");

    // Asynchronous reset while chain_in is high.
    @(negedge clk);
    pulse_width = 5; gap_width = 1; num_pulses = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("arst.pre_chain_in", 32'(chain_in), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst.chain_in", 32'(chain_in), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.out_edges", 32'(out_edges), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst.idle_busy", 32'(busy), 32'd0);
    run_train(3, 2, 2, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nor_chain_pulse_sequencer.md
Name: nor_chain_pulse_sequencer

Overview:
- Clocked stimulus controller for the NOR/INV delay chains under test.
- Drives the chain input with a programmed train of high pulses. Pulse width, gap and pulse count are set in clock cycles.
- Waits a settle window after the train, then signals completion.
- Optionally synchronises the chain output and counts its edges, so pulse propagation and degradation through the chain can be checked against the delay model.

Parameters:
- CNT_W, 16, width of the pulse_width and gap_width fields and of the phase counter
- NP_W, 8, width of num_pulses
- SETTLE_CYC, 64, cycles chain_in is held low after the last pulse before done
- EDGE_W, 16, width of the out_edges counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- abort  input  1  synchronous abort of a running train
- pulse_width  input  CNT_W  high-phase length in cycles; 0 is treated as 1
- gap_width  input  CNT_W  low-phase length between pulses; 0 is treated as 1
- num_pulses  input  NP_W  number of pulses; 0 means no pulse, settle only
- chain_in  output  1  registered drive to the chain input (myin)
- chain_out  input  1  chain output (myout); asynchronous to clk
- busy  output  1  high in HIGH, LOW and SETTLE
- done  output  1  one-cycle completion pulse
- out_edges  output  EDGE_W  count of synchronised chain_out edges during the run

Behaviour:
- Reset: state=IDLE, chain_in=0, busy=0, done=0, out_edges=0, all counters 0. chain_in is forced low asynchronously.
- FSM states: IDLE, HIGH, LOW, SETTLE, DONE.
- Launch from IDLE: start=1 at edge T latches pulse_width, gap_width and num_pulses. Later input changes do not affect the run.
  - num_pulses>0: go to HIGH. chain_in=1 and busy=1 from T+1.
  - num_pulses=0: go to SETTLE. chain_in stays 0.
- HIGH: chain_in=1 for exactly max(pw,1) cycles.
  - If pulses remain: go to LOW.
  - Otherwise: go to SETTLE.
- LOW: chain_in=0 for exactly max(gap,1) cycles, then HIGH. The pulse-remaining counter decrements on each HIGH exit.
- SETTLE: chain_in=0 for SETTLE_CYC cycles, then DONE.
- DONE: lasts 1 cycle with done=1 and busy=0, then IDLE. start is ignored in DONE.
- The train therefore spans num_pulses*pw + (num_pulses-1)*gap cycles, followed by SETTLE_CYC cycles.
- start is ignored while busy; there is no queuing.
- abort=1 while busy: on the next edge go to IDLE with chain_in=0 and busy=0. No done pulse; out_edges is held. abort in IDLE or DONE has no effect.
- If start and abort are both high in IDLE, start wins.
- Reset mid-train: immediate return to the reset values; no done pulse.
- chain_in is driven only from a flop. There is no combinational path from any input to chain_in.
- Phase counters load on state entry and count down to 1. There is no wrap; a full-scale value of 2^CNT_W-1 must work.

Optional Feature:
- Macro: NOR_CHAIN_EDGE_COUNT_EN
- Defined:
  - chain_out passes through a 2-flop synchroniser. An edge is detected by XOR of sync stage 2 with a third flop.
  - out_edges clears on an accepted start and increments on each detected edge while busy.
  - The count saturates at 2^EDGE_W-1 and holds its value after done or abort until the next start.
- Undefined:
  - No synchroniser flops are built; out_edges is tied to 0 and chain_out is unused.
  - All other behaviour is identical.

Test Plan:
- Reset release, then start with pw=3, gap=2, np=2 -> chain_in is 1 on T+1..T+3, 0 on T+4..T+5, 1 on T+6..T+8, then 0. done=1 on cycle T+8+SETTLE_CYC+1. busy is low in that cycle.
- pw=0, gap=0, np=3 -> three 1-cycle highs separated by 1-cycle lows (1,0,1,0,1); one done pulse.
- np=0 -> chain_in never rises; done after SETTLE_CYC+1 cycles; out_edges=0.
- start re-asserted mid-train, then abort during the second HIGH -> the extra start has no effect. After abort, chain_in=0 and busy=0 at the next edge, with no done pulse.
- With NOR_CHAIN_EDGE_COUNT_EN and chain_out looped back through a 5-cycle delay model, pw=4, gap=4, np=3 -> out_edges=6 at done. Without the macro, out_edges=0.
- rst asserted asynchronously while chain_in=1 -> chain_in drops before the next clk edge. After rst release the FSM is in IDLE and a fresh start behaves as in the first scenario.
